reservation_station: RTL
========================

Name: reservation_station

Overview:
- Single-hart LR/SC reservation tracker that sits directly beside the atomic unit.
- Consumes the atomic unit's lr_valid/lr_addr and sc_valid/sc_addr strobes and returns sc_success.
- Holds one reservation at granule resolution.
- The reservation is invalidated by:
  - SC consumption
  - snooped stores to the reserved granule (same-hart regular stores, DMA, other masters)
  - traps / xRET
  - a forward-progress timeout

Parameters:
- XLEN, 32: address width.
- GRANULE_BITS, 3: log2 of reservation granule in bytes. Address match uses addr[XLEN-1:GRANULE_BITS].
- TIMEOUT, 1023: cycles a reservation survives without SC. 0 disables timeout. Legal range 0..65535.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- lr_valid  input  1  one-cycle pulse: LR read completed, set reservation
- lr_addr  input  XLEN  LR address
- sc_valid  input  1  SC checking; held high for 1..N consecutive cycles per SC
- sc_addr  input  XLEN  SC address
- sc_success  output  1  SC may write; valid every cycle sc_valid=1
- inv_store_valid  input  1  store observed this cycle
- inv_store_addr  input  XLEN  address of observed store
- inv_trap  input  1  trap entry or xRET this cycle; clears reservation
- rsv_valid  output  1  reservation currently held
- rsv_addr  output  XLEN  reserved address, granule-aligned (low GRANULE_BITS zero)
- sc_fail_count  output  16  saturating count of failed SCs (debug)

Behaviour:
- Reset (async) values:
  - rsv_valid=0, rsv_addr=0, timeout counter=0
  - sc_result_q=0, sc_valid_d=0, sc_fail_count=0
  - sc_success=0
- Granule match: match(a) = rsv_valid && (a[XLEN-1:GRANULE_BITS] == rsv_addr[XLEN-1:GRANULE_BITS]).
- SC burst detection:
  - sc_first = sc_valid && !sc_valid_d, where sc_valid_d is sc_valid registered.
  - sc_valid_d is cleared at reset.
- sc_success (combinational output):
  - When sc_first=1: sc_success = match(sc_addr) && !inv_trap && !(inv_store_valid && match(inv_store_addr)). Same-cycle invalidation forces failure.
  - When sc_valid=1 && !sc_first: sc_success = sc_result_q. The verdict is frozen for the rest of the burst.
  - When sc_valid=0: sc_success = 0.
- On the sc_first cycle:
  - sc_result_q <= live verdict.
  - rsv_valid <= 0, whether the SC passed or failed.
  - If the verdict is 0, sc_fail_count increments, saturating at 16'hFFFF.
- lr_valid (register update, next edge):
  - rsv_valid <= 1.
  - rsv_addr <= lr_addr with low GRANULE_BITS zeroed.
  - Timeout counter <= TIMEOUT.
  - A new LR overwrites any existing reservation.
- Invalidation while no LR and no sc_first is present; any of these clears rsv_valid next edge:
  - inv_trap=1
  - inv_store_valid && match(inv_store_addr)
  - timeout counter transitions 1->0 while rsv_valid and TIMEOUT!=0
  - A store to a different granule has no effect.
- Timeout counter:
  - Decrements by 1 each cycle while rsv_valid=1 and counter>0.
  - Holds at 0.
  - With TIMEOUT=0 the counter is never loaded and timeout never fires.
- Priority on one edge: reset > lr_valid > sc_first clear > trap > store snoop > timeout.
  - lr_valid together with inv_trap or a matching store: the new reservation is kept.
  - lr_valid && sc_valid together is illegal. Assertion under simulation; lr_valid wins.
- No latency on sc_success. Reservation state updates one cycle after the triggering event.
- Reset mid-SC-burst:
  - Reservation is lost; sc_success goes to 0 immediately.
  - sc_valid_d=0, so the next cycle with sc_valid=1 is treated as a new sc_first and fails.

Test Plan:
1. LR success:
   - LR pulse, lr_addr=0x8000_1004, 3 idle cycles, then SC burst of 2 cycles at sc_addr=0x8000_1000.
   - Required: rsv_addr=0x8000_1000; sc_success=1 both cycles; rsv_valid=0 after first SC cycle; sc_fail_count=0.
2. Address mismatch and no-reservation SC:
   - LR at 0x8000_1000, then SC at 0x8000_1010 -> sc_success=0 for the whole burst; sc_fail_count=1.
   - Second SC at 0x8000_1000 -> sc_success=0 (reservation consumed); sc_fail_count=2.
3. Store snoop:
   - LR at 0x2000, then inv_store at 0x2004 (same granule), then SC at 0x2000 -> sc_success=0.
   - Repeat with store to 0x2008 -> sc_success=1.
4. Same-cycle races:
   - Matching inv_store_valid on the sc_first cycle -> sc_success=0 for the entire burst.
   - lr_valid at 0x3000 with inv_trap in the same cycle -> rsv_valid=1, rsv_addr=0x3000.
5. Timeout:
   - TIMEOUT=4, LR at 0x4000, no SC -> rsv_valid drops exactly 4 cycles after the load edge; later SC fails.
   - TIMEOUT=0 -> reservation held for 10000 cycles and SC succeeds.
6. Reset and trap:
   - inv_trap one cycle after LR -> SC fails.
   - Async reset asserted mid-SC-burst -> sc_success=0 combinationally, all outputs return to reset values, sc_fail_count=0.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station: single-hart LR/SC reservation tracker beside the atomic unit.
// It holds one granule-aligned reservation. The reservation is set by LR. It is
// cleared by SC consumption, by a snooped store to the same granule, by a trap or
// xRET, or by a forward-progress timeout. sc_success is combinational. Its verdict
// is taken on the first cycle of an SC burst and held for the rest of that burst.
module reservation_station #(
   parameter int XLEN         = 32,
   parameter int GRANULE_BITS = 3,
   parameter int TIMEOUT      = 1023
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            lr_valid,
   input  logic [XLEN-1:0] lr_addr,
   input  logic            sc_valid,
   input  logic [XLEN-1:0] sc_addr,
   output logic            sc_success,
   input  logic            inv_store_valid,
   input  logic [XLEN-1:0] inv_store_addr,
   input  logic            inv_trap,
   output logic            rsv_valid,
   output logic [XLEN-1:0] rsv_addr,
   output logic [15:0]     sc_fail_count
);

   localparam logic [XLEN-1:0] GRANULE_MASK = {XLEN{1'b1}} << GRANULE_BITS;
   localparam logic [15:0]     TIMEOUT_LOAD = 16'(TIMEOUT);
   localparam logic            TIMEOUT_EN   = (TIMEOUT != 0);

   // Two addresses fall in the same reservation granule
   function automatic logic same_granule(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      return (a & GRANULE_MASK) == (b & GRANULE_MASK);
   endfunction

   logic            rsv_valid_r;
   logic [XLEN-1:0] rsv_addr_r;
   logic [15:0]     tmo_cnt_r;
   logic            sc_result_r;
   logic            sc_valid_d_r;
   logic [15:0]     fail_cnt_r;

   logic sc_first_s;
   logic sc_match_s;
   logic store_hit_s;
   logic live_verdict_s;
   logic timeout_fire_s;
   logic sc_success_s;

   // Live SC verdict, snoop hit, timeout expiry and the burst-frozen success output
   always_comb begin
      sc_first_s     = 1'b0;
      sc_match_s     = 1'b0;
      store_hit_s    = 1'b0;
      live_verdict_s = 1'b0;
      timeout_fire_s = 1'b0;
      sc_success_s   = 1'b0;
      sc_first_s     = sc_valid && !sc_valid_d_r;
      sc_match_s     = rsv_valid_r && same_granule(sc_addr, rsv_addr_r);
      store_hit_s    = inv_store_valid && rsv_valid_r && same_granule(inv_store_addr, rsv_addr_r);
      live_verdict_s = sc_match_s && !inv_trap && !store_hit_s;
      timeout_fire_s = TIMEOUT_EN && rsv_valid_r && (tmo_cnt_r == 16'd1);
      if (!sc_valid) begin
         sc_success_s = 1'b0;
      end else if (sc_first_s) begin
         sc_success_s = live_verdict_s;
      end else begin
         sc_success_s = sc_result_r;
      end
   end

   // Track SC bursts and freeze the verdict on the first cycle of each burst
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sc_valid_d_r <= 1'b0;
         sc_result_r  <= 1'b0;
      end else begin
         sc_valid_d_r <= sc_valid;
         if (sc_first_s) begin
            sc_result_r <= live_verdict_s;
         end else begin
            sc_result_r <= sc_result_r;
         end
      end
   end

   // Reservation register: LR sets it and overrides every invalidation source
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsv_valid_r <= 1'b0;
         rsv_addr_r  <= {XLEN{1'b0}};
      end else if (lr_valid) begin
         rsv_valid_r <= 1'b1;
         rsv_addr_r  <= lr_addr & GRANULE_MASK;
      end else if (sc_first_s || inv_trap || store_hit_s || timeout_fire_s) begin
         rsv_valid_r <= 1'b0;
      end else begin
         rsv_valid_r <= rsv_valid_r;
      end
   end

   // Forward-progress counter: loaded by LR and counting down while a reservation is held
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_r <= 16'd0;
      end else if (lr_valid) begin
         tmo_cnt_r <= TIMEOUT_LOAD;
      end else if (rsv_valid_r && (tmo_cnt_r != 16'd0)) begin
         tmo_cnt_r <= tmo_cnt_r - 16'd1;
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // Saturating debug count of SCs whose verdict was failure
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fail_cnt_r <= 16'd0;
      end else if (sc_first_s && !live_verdict_s && (fail_cnt_r != 16'hFFFF)) begin
         fail_cnt_r <= fail_cnt_r + 16'd1;
      end else begin
         fail_cnt_r <= fail_cnt_r;
      end
   end

   assign sc_success    = sc_success_s;
   assign rsv_valid     = rsv_valid_r;
   assign rsv_addr      = rsv_addr_r;
   assign sc_fail_count = fail_cnt_r;

   reservation_station_chk u_chk (
      .clk      (clk),
      .reset    (reset),
      .lr_valid (lr_valid),
      .sc_valid (sc_valid)
   );

endmodule

// reservation_station_chk: protocol checks on the atomic-unit strobes.
module reservation_station_chk (
   input logic clk,
   input logic reset,
   input logic lr_valid,
   input logic sc_valid
);

   a_no_lr_with_sc: assert property (@(posedge clk) disable iff (reset) !(lr_valid && sc_valid));

endmodule
